// File: rtl/fir_8tap.sv
// 8-tap direct-form FIR: 16-bit signed samples in, registered 32-bit signed sum out, one sample per clock.
// Optional macro FIR_VALID_EN adds a registered Yvalid flag that rises once all eight taps hold post-reset samples.
module fir_8tap #(
  parameter logic signed [15:0] COEF0 = -16'sd2,
  parameter logic signed [15:0] COEF1 = -16'sd1,
  parameter logic signed [15:0] COEF2 = 16'sd3,
  parameter logic signed [15:0] COEF3 = 16'sd4,
  parameter logic signed [15:0] COEF4 = 16'sd4,
  parameter logic signed [15:0] COEF5 = 16'sd3,
  parameter logic signed [15:0] COEF6 = -16'sd1,
  parameter logic signed [15:0] COEF7 = -16'sd2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic signed [15:0] Xin,
`ifdef FIR_VALID_EN
  output logic signed [31:0] Yout,
  output logic               Yvalid
`else
  output logic signed [31:0] Yout
`endif
);

  localparam logic signed [15:0] COEF [8] = '{COEF0, COEF1, COEF2, COEF3,
                                              COEF4, COEF5, COEF6, COEF7};

  logic signed [15:0] x_q [8];
  logic signed [15:0] x_d [8];
  logic signed [31:0] yout_q;
  logic signed [31:0] yout_d;

  always_comb begin
    x_d[0] = Xin;
    for (int k = 1; k < 8; k++) begin
      x_d[k] = x_q[k-1];
    end
  end

  // The sum is formed from the pre-shift taps; products keep their low 32 bits, so the total wraps mod 2^32.
  always_comb begin
    yout_d = 32'sd0;
    for (int k = 0; k < 8; k++) begin
      yout_d = yout_d + (32'(x_q[k]) * 32'(COEF[k]));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 8; k++) begin
        x_q[k] <= 16'sd0;
      end
      yout_q <= 32'sd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        x_q[k] <= x_d[k];
      end
      yout_q <= yout_d;
    end
  end

  assign Yout = yout_q;

`ifdef FIR_VALID_EN
  logic [3:0] fill_q;
  logic [3:0] fill_d;
  logic       yvalid_q;
  logic       yvalid_d;

  always_comb begin
    fill_d   = (fill_q == 4'd9) ? fill_q : fill_q + 4'd1;
    yvalid_d = (fill_d == 4'd9);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fill_q   <= 4'd0;
      yvalid_q <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      yvalid_q <= yvalid_d;
    end
  end

  assign Yvalid = yvalid_q;
`endif

endmodule

// File: tb/tb_fir_8tap.sv
// Bench for fir_8tap: directed patterns and random streams checked against a sample-history model.
module tb_fir_8tap;
  logic               Clk;
  logic               Reset;
  logic signed [15:0] Xin;
  logic signed [31:0] Yout;
`ifdef FIR_VALID_EN
  logic               Yvalid;
`endif

  int checks;
  int failures;

  int coefs [8] = '{-2, -1, 3, 4, 4, 3, -1, -2};
  int hist [$];

  fir_8tap dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Xin   (Xin),
`ifdef FIR_VALID_EN
    .Yout  (Yout),
    .Yvalid(Yvalid)
`else
    .Yout  (Yout)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected output after the latest edge: each sample shows up one edge after it was captured.
  function automatic logic signed [31:0] model_y();
    longint acc;
    int idx;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      idx = hist.size() - 2 - k;
      if (idx >= 0) acc += longint'(coefs[k]) * longint'(hist[idx]);
    end
    return acc[31:0];
  endfunction

  function automatic logic model_vld();
    return hist.size() >= 9;
  endfunction

  task automatic tick(input int x);
    Xin = 16'(x);
    @(posedge Clk);
    hist.push_back(x);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    Xin   = 16'sd0;
    @(posedge Clk);
    hist.delete();
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Xin = 16'sd0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    hist.delete();
    #1;
    Reset = 1'b0;
    checks++;
    if (Yout !== 32'sd0) begin
      failures++;
      $display("FAIL reset_yout got=%0d want=0", Yout);
    end
`ifdef FIR_VALID_EN
    checks++;
    if (Yvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_yvalid got=%b want=0", Yvalid);
    end
`endif
  endtask

  task automatic test_impulse();
    int exp_tab [10] = '{0, -2, -1, 3, 4, 4, 3, -1, -2, 0};
    pulse_reset();
    tick(1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (Yout !== 32'(exp_tab[i])) begin
        failures++;
        $display("FAIL impulse[%0d] got=%0d want=%0d", i + 1, Yout, exp_tab[i]);
      end
      tick(0);
    end
  endtask

  task automatic test_step();
    int exp_tab [11] = '{0, -200, -300, 0, 400, 800, 1100, 1000, 800, 800, 800};
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      tick(100);
      checks++;
      if (Yout !== 32'(exp_tab[i])) begin
        failures++;
        $display("FAIL step[%0d] got=%0d want=%0d", i + 1, Yout, exp_tab[i]);
      end
`ifdef FIR_VALID_EN
      checks++;
      if (Yvalid !== (i >= 8)) begin
        failures++;
        $display("FAIL step_yvalid[%0d] got=%b want=%b", i + 1, Yvalid, (i >= 8));
      end
`endif
    end
  endtask

  task automatic test_full_scale();
    pulse_reset();
    repeat (12) tick(-32768);
    checks++;
    if (Yout !== 32'hFFFC0000) begin
      failures++;
      $display("FAIL neg_full_scale got=%h want=fffc0000", Yout);
    end
    pulse_reset();
    repeat (12) tick(32767);
    checks++;
    if (Yout !== 32'h0003FFF8) begin
      failures++;
      $display("FAIL pos_full_scale got=%h want=0003fff8", Yout);
    end
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    repeat (12) tick(100);
    checks++;
    if (Yout !== 32'sd800) begin
      failures++;
      $display("FAIL mid_pre_steady got=%0d want=800", Yout);
    end
    Reset = 1'b1;
    Xin   = 16'sd100;
    @(posedge Clk);
    hist.delete();
    #1;
    Reset = 1'b0;
    checks++;
    if (Yout !== 32'sd0) begin
      failures++;
      $display("FAIL mid_reset_yout got=%0d want=0", Yout);
    end
`ifdef FIR_VALID_EN
    checks++;
    if (Yvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_yvalid got=%b want=0", Yvalid);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      tick(100);
      checks++;
      if (Yout !== model_y()) begin
        failures++;
        $display("FAIL mid_refill[%0d] got=%0d want=%0d", i + 1, Yout, model_y());
      end
`ifdef FIR_VALID_EN
      checks++;
      if (Yvalid !== model_vld()) begin
        failures++;
        $display("FAIL mid_refill_yvalid[%0d] got=%b want=%b", i + 1, Yvalid, model_vld());
      end
`endif
    end
  endtask

  task automatic test_alternating();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      tick((i % 2 == 0) ? 1000 : -1000);
      if (i >= 10) begin
        checks++;
        if (Yout !== model_y()) begin
          failures++;
          $display("FAIL alternating[%0d] got=%0d want=%0d", i + 1, Yout, model_y());
        end
      end
    end
  endtask

  task automatic test_random();
    int x;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
        checks++;
        if (Yout !== 32'sd0) begin
          failures++;
          $display("FAIL random_reset[%0d] got=%0d want=0", i, Yout);
        end
      end
      x = int'($signed(16'($urandom)));
      tick(x);
      checks++;
      if (Yout !== model_y()) begin
        failures++;
        $display("FAIL random[%0d] got=%0d want=%0d", i, Yout, model_y());
      end
`ifdef FIR_VALID_EN
      checks++;
      if (Yvalid !== model_vld()) begin
        failures++;
        $display("FAIL random_yvalid[%0d] got=%b want=%b", i, Yvalid, model_vld());
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    Xin      = 16'sd0;
    test_reset();
    test_impulse();
    test_step();
    test_full_scale();
    test_reset_midstream();
    test_alternating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
